alu_request_scheduler: RTL and testbench
========================================

Name: alu_request_scheduler

Overview:
Shares one ALU (one-hot control unit plus A/Q/M datapath) among NUM_REQ requesters. Picks requesters round-robin, latches operands, and issues BEGIN/op_code. Drives INBUS in step with the control unit's load strobes, captures OUTBUS on its push strobes, and returns a tagged result. Handles divide-by-zero locally, because the ALU's leading-zero loop never terminates when M=0.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
W, 8, ALU data width (A/Q/M/INBUS/OUTBUS)
TIMEOUT_CYCLES, 64, watchdog limit (used only with ALU_WATCHDOG_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request
req_op  in  2*NUM_REQ  op code: 00 add, 01 sub, 10 mul, 11 div
req_x  in  W*NUM_REQ  add/sub first operand; mul multiplicand(Q); div dividend high(A)
req_y  in  W*NUM_REQ  add/sub/mul second operand(M); div divisor(M)
req_z  in  W*NUM_REQ  div dividend low(Q); ignored otherwise
req_ready  out  NUM_REQ  one-cycle accept pulse, onehot0
resp_valid  out  1  result valid, held until resp_ready
resp_ready  in  1  consumer accept
resp_id  out  clog2(NUM_REQ)  requester index of result
resp_hi  out  W  A result (sum/diff, product high, remainder)
resp_lo  out  W  Q result (product low, quotient; 0 for add/sub)
resp_err  out  1  1 = divide by zero (or timeout)
alu_begin  out  1  BEGIN pulse to control unit
alu_op  out  2  op_code to control unit, stable from grant to END
alu_reset_n  out  1  active-low ALU reset = ~reset (& ~abort with watchdog)
alu_load_a, alu_load_q, alu_load_m  in  1 each  control-unit INBUS load strobes
alu_push_a, alu_push_q  in  1 each  control-unit OUTBUS push strobes
alu_inbus  out  W  INBUS data
alu_outbus  in  W  OUTBUS data
alu_end  in  1  END from control unit

Behaviour:
- Reset values: all outputs 0 except alu_reset_n=0 during reset. State IDLE, rr pointer 0.
- FSM states: IDLE, ISSUE, LOAD_RUN, DRAIN, RESP.
- IDLE: if any req_valid, pick the first set bit at or after the pointer (wrapping), pulse req_ready[g], latch op/x/y/z and id, set pointer=g+1 mod NUM_REQ.
  - If op=11 and y=0: go straight to RESP with err=1, hi=lo=0. The ALU is never started.
  - Otherwise go to ISSUE.
- ISSUE: alu_begin=1 for exactly one cycle, alu_op=latched op. Go to LOAD_RUN.
- LOAD_RUN: alu_inbus is combinational.
  - load_a: x
  - load_q: z for div, x for mul
  - load_m: y
  - otherwise 0
  - Simultaneous strobes are a protocol error: priority a > q > m.
- Push strobes register; OUTBUS is sampled the cycle after the strobe. Delayed push_a -> hi, delayed push_q -> lo.
- alu_end in LOAD_RUN -> DRAIN.
- DRAIN: one cycle to capture the final delayed push, then RESP.
- RESP: resp_valid=1 with id/hi/lo/err stable. On resp_ready go to IDLE; a new grant is possible on the next cycle, not the same one.
- Requests arriving while busy are held off (no req_ready). Withdrawing req_valid before grant is legal.
- The latch is taken at grant; later operand changes are ignored.
- Fairness: each continuously-valid requester is granted within NUM_REQ grants.
- Async reset mid-operation: FSM goes to IDLE immediately, resp_valid drops, alu_reset_n=0 for the duration of reset.
- Latency (ALU-dependent): grant to resp_valid = 3 + ALU cycles to END + 1.

Optional Feature:
ALU_WATCHDOG_EN.
- When defined: a cycle counter runs in LOAD_RUN. Reaching TIMEOUT_CYCLES without alu_end causes:
  - alu_reset_n=0 for one cycle (abort)
  - RESP with err=1, hi=lo=0
  - the counter clears on every grant.
- When undefined: no counter. LOAD_RUN waits indefinitely and alu_reset_n=~reset.

Decomposition:
- Package alu_sched_pkg: op-code constants (OP_ADD..OP_DIV), FSM state encoding, id width function.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin grant with pointer update. Instantiated once.

Test Plan:
- Single req0 add x=0x05 y=0x03 -> alu_inbus 0x05 on load_a, 0x03 on load_m; resp_id=0, hi=0x08, lo=0, err=0.
- req1 mul x=0x07 y=0x06 -> inbus 0x07 on load_q, 0x06 on load_m; resp hi=0x00, lo=0x2A.
- req2 div x=0x00 z=0x64 y=0x07 -> resp lo=0x0E, hi=0x02.
- req3 div y=0 -> resp_err=1 the cycle after grant, alu_begin never asserted.
- All four req_valid held, pointer=0 -> grant order 0,1,2,3,0. resp_ready held low 5 cycles -> resp stable and no new grant.
- Reset asserted mid-mul -> outputs zero, alu_reset_n=0. After release, a pending req1 is granted first from pointer 0 (if req0 idle). With ALU_WATCHDOG_EN, alu_end tied 0 -> err after 64 cycles.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU request scheduler: op codes, FSM state
// encoding and the requester-id width helper.
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_LOAD_RUN = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_RESP     = 3'd4;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_request_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after the
// pointer (wrapping) and moves the pointer one past the winner on advance.
module rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_id,
  output logic               grant_any
);

  logic [IW-1:0] ptr;
  int            idx;

  // Search from the pointer upward, wrapping, for the first active request
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!grant_any && req[idx]) begin
        grant_any = 1'b1;
        grant_id  = IW'(idx);
      end
    end
    grant = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
  end

  // Pointer moves one past the winner so it drops to lowest priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && grant_any) begin
      ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/alu_request_scheduler.sv
// Shares one one-hot-control ALU among NUM_REQ requesters. Operands are
// latched at grant, fed onto INBUS as the control unit strobes its loads,
// and results are captured from OUTBUS one cycle after each push strobe.
// Divide by zero is answered locally since the ALU would never finish.
// Optional build macro ALU_WATCHDOG_EN adds a LOAD_RUN timeout that aborts
// the ALU through alu_reset_n and returns an error response.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   IDLE      | waiting for a request; grant, latch operands
//   ISSUE     | one-cycle BEGIN pulse to the control unit
//   LOAD_RUN  | serve INBUS loads, capture pushes, wait for END
//   DRAIN     | capture the push that coincided with END
//   RESP      | hold tagged result until resp_ready
module alu_request_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int W              = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [2*NUM_REQ-1:0]          req_op,
  input  logic [W*NUM_REQ-1:0]          req_x,
  input  logic [W*NUM_REQ-1:0]          req_y,
  input  logic [W*NUM_REQ-1:0]          req_z,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [id_width(NUM_REQ)-1:0]  resp_id,
  output logic [W-1:0]                  resp_hi,
  output logic [W-1:0]                  resp_lo,
  output logic                          resp_err,
  output logic                          alu_begin,
  output logic [1:0]                    alu_op,
  output logic                          alu_reset_n,
  input  logic                          alu_load_a,
  input  logic                          alu_load_q,
  input  logic                          alu_load_m,
  input  logic                          alu_push_a,
  input  logic                          alu_push_q,
  output logic [W-1:0]                  alu_inbus,
  input  logic [W-1:0]                  alu_outbus,
  input  logic                          alu_end
);

  localparam int IW = id_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("alu_request_scheduler: NUM_REQ must be 2..8, TIMEOUT_CYCLES >= 1");
  end

  logic [2:0]         state;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_id;
  logic               grant_any;
  logic               in_idle;
  logic [1:0]         sel_op;
  logic [W-1:0]       sel_x, sel_y, sel_z;
  logic [1:0]         op_q;
  logic [W-1:0]       x_q, y_q, z_q, hi_q, lo_q;
  logic [IW-1:0]      id_q;
  logic               err_q;
  logic               push_a_d, push_q_d;

  assign in_idle = (state == ST_IDLE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (in_idle),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // Operand fields of the current arbitration winner
  always_comb begin
    sel_op = req_op[2*int'(grant_id) +: 2];
    sel_x  = req_x[W*int'(grant_id) +: W];
    sel_y  = req_y[W*int'(grant_id) +: W];
    sel_z  = req_z[W*int'(grant_id) +: W];
  end

`ifdef ALU_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            abort_q;

  assign wd_expire = (state == ST_LOAD_RUN) && (wd_cnt == '0) && !alu_end;

  // Down-counter reloaded at grant, terminal count aborts a stuck ALU
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt  <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= wd_expire;
      if (in_idle && grant_any) begin
        wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
      end else if (state == ST_LOAD_RUN && wd_cnt != '0) begin
        wd_cnt <= wd_cnt - 1'b1;
      end
    end
  end

  assign alu_reset_n = ~reset & ~abort_q;
`else
  assign alu_reset_n = ~reset;
`endif

  // Main sequencing FSM with operand latch and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_ADD;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      id_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      err_q    <= 1'b0;
      push_a_d <= 1'b0;
      push_q_d <= 1'b0;
    end else begin
      push_a_d <= alu_push_a;
      push_q_d <= alu_push_q;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            op_q  <= sel_op;
            x_q   <= sel_x;
            y_q   <= sel_y;
            z_q   <= sel_z;
            id_q  <= grant_id;
            hi_q  <= '0;
            lo_q  <= '0;
            if (sel_op == OP_DIV && sel_y == '0) begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end else begin
              err_q <= 1'b0;
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state <= ST_LOAD_RUN;
        ST_LOAD_RUN: begin
          if (push_a_d) hi_q <= alu_outbus;
          if (push_q_d) lo_q <= alu_outbus;
`ifdef ALU_WATCHDOG_EN
          if (wd_expire) begin
            hi_q  <= '0;
            lo_q  <= '0;
            err_q <= 1'b1;
            state <= ST_RESP;
          end else
`endif
          if (alu_end) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (push_a_d) hi_q <= alu_outbus;
          if (push_q_d) lo_q <= alu_outbus;
          state <= ST_RESP;
        end
        ST_RESP: if (resp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // INBUS follows the load strobes; simultaneous strobes resolve a > q > m
  always_comb begin
    alu_inbus = '0;
    if (state == ST_LOAD_RUN) begin
      if (alu_load_a)      alu_inbus = x_q;
      else if (alu_load_q) alu_inbus = (op_q == OP_DIV) ? z_q : x_q;
      else if (alu_load_m) alu_inbus = y_q;
    end
  end

  assign req_ready  = (in_idle && !reset) ? grant : '0;
  assign alu_begin  = (state == ST_ISSUE);
  assign alu_op     = op_q;
  assign resp_valid = (state == ST_RESP);
  assign resp_id    = id_q;
  assign resp_hi    = hi_q;
  assign resp_lo    = lo_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_alu_request_scheduler.sv
// Scoreboard bench: stimulus pushes hand-computed responses and ALU load
// expectations; a behavioural control-unit model serves the ALU handshake
// and a monitor pops and compares every accepted response.
module tb_alu_request_scheduler;
  import alu_sched_pkg::*;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       err;
  } resp_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] q;
    logic [7:0] m;
  } alu_exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [31:0] req_x, req_y, req_z;
  logic [3:0]  req_ready;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_id;
  logic [7:0]  resp_hi, resp_lo;
  logic        resp_err;
  logic        alu_begin;
  logic [1:0]  alu_op;
  logic        alu_reset_n;
  logic        alu_load_a, alu_load_q, alu_load_m, alu_push_a, alu_push_q;
  logic [7:0]  alu_inbus, alu_outbus;
  logic        alu_end;

  int n_tests = 0;
  int n_fail = 0;
  int resp_cnt = 0;
  int begin_cnt = 0;
  int abort_cnt = 0;
  bit alu_hang = 0;
  resp_t    sb_q[$];
  alu_exp_t alu_q[$];

  alu_request_scheduler #(.NUM_REQ(4), .W(8), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_hi(resp_hi), .resp_lo(resp_lo), .resp_err(resp_err),
    .alu_begin(alu_begin), .alu_op(alu_op), .alu_reset_n(alu_reset_n),
    .alu_load_a(alu_load_a), .alu_load_q(alu_load_q), .alu_load_m(alu_load_m),
    .alu_push_a(alu_push_a), .alu_push_q(alu_push_q),
    .alu_inbus(alu_inbus), .alu_outbus(alu_outbus), .alu_end(alu_end)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare each accepted response with the queue head
  initial begin
    resp_t got;
    forever begin
      @(negedge clk);
      #3;
      if (resp_valid && resp_ready) begin
        got = '{id: resp_id, hi: resp_hi, lo: resp_lo, err: resp_err};
        if (sb_q.size() == 0) begin
          check("resp_unexpected", 32'(got), 32'hFFFF_FFFF);
        end else begin
          check("resp", 32'(got), 32'(sb_q.pop_front()));
        end
        resp_cnt++;
      end
    end
  end

  // Count BEGIN pulses and ALU aborts outside reset
  initial begin
    forever begin
      @(negedge clk);
      if (alu_begin) begin_cnt++;
      if (!alu_reset_n && !reset) abort_cnt++;
    end
  end

  task automatic alu_tick(output logic ok);
    @(negedge clk);
    ok = alu_reset_n;
    if (!ok) begin
      alu_load_a = 0; alu_load_q = 0; alu_load_m = 0;
      alu_push_a = 0; alu_push_q = 0; alu_end = 0; alu_outbus = '0;
    end
  endtask

  task automatic alu_run(input alu_exp_t e);
    logic ok, single;
    logic [7:0] a, q, m;
    logic [15:0] wide;
    a = '0; q = '0; m = '0;
    single = !e.op[1];
    check("alu_op", 32'(alu_op), 32'(e.op));
    if (e.op != OP_MUL) begin
      alu_tick(ok); if (!ok) return;
      alu_load_a = 1; #1 a = alu_inbus; check("inbus_a", 32'(a), 32'(e.a));
    end
    if (e.op[1]) begin
      alu_tick(ok); if (!ok) return;
      alu_load_a = 0; alu_load_q = 1; #1 q = alu_inbus; check("inbus_q", 32'(q), 32'(e.q));
    end
    alu_tick(ok); if (!ok) return;
    alu_load_a = 0; alu_load_q = 0; alu_load_m = 1; #1 m = alu_inbus;
    check("inbus_m", 32'(m), 32'(e.m));
    alu_tick(ok); if (!ok) return;
    alu_load_m = 0;
    if (alu_hang) return;
    case (e.op)
      OP_ADD: a = a + m;
      OP_SUB: a = a - m;
      OP_MUL: begin wide = {8'h00, q} * {8'h00, m}; a = wide[15:8]; q = wide[7:0]; end
      default: begin
        wide = {a, q};
        q = 8'(wide / {8'h00, m});
        a = 8'(wide % {8'h00, m});
      end
    endcase
    alu_tick(ok); if (!ok) return;
    alu_push_a = 1; alu_end = single;
    alu_tick(ok); if (!ok) return;
    alu_push_a = 0; alu_outbus = a; alu_push_q = !single; alu_end = !single;
    alu_tick(ok); if (!ok) return;
    alu_push_q = 0; alu_end = 0; alu_outbus = q;
    alu_tick(ok); if (!ok) return;
    alu_outbus = '0;
  endtask

  // Behavioural control unit: run one op per BEGIN pulse
  initial begin
    alu_load_a = 0; alu_load_q = 0; alu_load_m = 0;
    alu_push_a = 0; alu_push_q = 0; alu_end = 0; alu_outbus = '0;
    forever begin
      @(negedge clk);
      if (alu_begin) begin
        if (alu_q.size() == 0) check("alu_begin_unexpected", 32'(alu_begin), 32'd0);
        else alu_run(alu_q.pop_front());
      end
    end
  end

  task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] z);
    req_op[2*id +: 2] = op;
    req_x[8*id +: 8]  = x;
    req_y[8*id +: 8]  = y;
    req_z[8*id +: 8]  = z;
    req_valid[id]     = 1'b1;
  endtask

  task automatic wait_grant(input int id, input bit drop);
    bit got;
    got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      #1;
      if (req_ready != '0) got = 1;
      else @(negedge clk);
    end
    check("grant_seen", 32'(got), 32'd1);
    if (got) check("grant_id", 32'(req_ready), 32'(1) << id);
    @(negedge clk);
    if (drop) req_valid[id] = 1'b0;
  endtask

  task automatic wait_resps(input int n);
    for (int c = 0; c < 1000 && resp_cnt < n; c++) @(negedge clk);
    check("resp_count", 32'(resp_cnt), 32'(n));
  endtask

  initial begin
    int b0;
    reset = 1; req_valid = '0; req_op = '0; req_x = '0; req_y = '0; req_z = '0;
    resp_ready = 1;
    repeat (3) @(negedge clk);
    check("rst_alu_reset_n", 32'(alu_reset_n), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_outputs", 32'({req_ready, alu_begin, alu_op, resp_id, resp_hi, resp_lo, resp_err}), 32'd0);
    @(negedge clk);
    reset = 0;
    #1 check("alu_reset_n_release", 32'(alu_reset_n), 32'd1);

    // add 5+3 from req0
    alu_q.push_back('{OP_ADD, 8'h05, 8'h00, 8'h03});
    sb_q.push_back('{2'd0, 8'h08, 8'h00, 1'b0});
    set_req(0, OP_ADD, 8'h05, 8'h03, 8'h00); wait_grant(0, 1); wait_resps(1);

    // mul 7*6 from req1
    alu_q.push_back('{OP_MUL, 8'h00, 8'h07, 8'h06});
    sb_q.push_back('{2'd1, 8'h00, 8'h2A, 1'b0});
    set_req(1, OP_MUL, 8'h07, 8'h06, 8'h00); wait_grant(1, 1); wait_resps(2);

    // div 0x0064/7 from req2
    alu_q.push_back('{OP_DIV, 8'h00, 8'h64, 8'h07});
    sb_q.push_back('{2'd2, 8'h02, 8'h0E, 1'b0});
    set_req(2, OP_DIV, 8'h00, 8'h07, 8'h64); wait_grant(2, 1); wait_resps(3);

    // divide by zero from req3: immediate error, no BEGIN
    b0 = begin_cnt;
    sb_q.push_back('{2'd3, 8'h00, 8'h00, 1'b1});
    set_req(3, OP_DIV, 8'h55, 8'h00, 8'h12); wait_grant(3, 1);
    #1 check("div0_resp_valid", 32'({resp_valid, resp_err}), 32'b11);
    wait_resps(4);
    check("div0_no_begin", 32'(begin_cnt), 32'(b0));

    // sub 3-5 from req3, consumer stalls while all requesters wait
    resp_ready = 0;
    alu_q.push_back('{OP_SUB, 8'h03, 8'h00, 8'h05});
    sb_q.push_back('{2'd3, 8'hFE, 8'h00, 1'b0});
    set_req(3, OP_SUB, 8'h03, 8'h05, 8'h00); wait_grant(3, 1);
    for (int c = 0; c < 200 && !resp_valid; c++) @(negedge clk);
    alu_q.push_back('{OP_ADD, 8'h11, 8'h00, 8'h22});
    alu_q.push_back('{OP_ADD, 8'h40, 8'h00, 8'h0F});
    alu_q.push_back('{OP_ADD, 8'hF0, 8'h00, 8'h20});
    alu_q.push_back('{OP_ADD, 8'h7F, 8'h00, 8'h01});
    alu_q.push_back('{OP_ADD, 8'h11, 8'h00, 8'h22});
    sb_q.push_back('{2'd0, 8'h33, 8'h00, 1'b0});
    sb_q.push_back('{2'd1, 8'h4F, 8'h00, 1'b0});
    sb_q.push_back('{2'd2, 8'h10, 8'h00, 1'b0});
    sb_q.push_back('{2'd3, 8'h80, 8'h00, 1'b0});
    sb_q.push_back('{2'd0, 8'h33, 8'h00, 1'b0});
    set_req(0, OP_ADD, 8'h11, 8'h22, 8'h00);
    set_req(1, OP_ADD, 8'h40, 8'h0F, 8'h00);
    set_req(2, OP_ADD, 8'hF0, 8'h20, 8'h00);
    set_req(3, OP_ADD, 8'h7F, 8'h01, 8'h00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("stall_hold", 32'({resp_valid, resp_id, resp_hi, req_ready}), {19'd0, 1'b1, 2'd3, 8'hFE, 4'h0});
    end
    #1 resp_ready = 1;
    check("no_same_cycle_grant", 32'(req_ready), 32'd0);
    for (int k = 0; k < 5; k++) wait_grant(k % 4, 0);
    req_valid = '0;
    wait_resps(10);

    // reset in the middle of a multiply; pointer returns to 0
    alu_q.push_back('{OP_MUL, 8'h00, 8'h09, 8'h0B});
    set_req(1, OP_MUL, 8'h09, 8'h0B, 8'h00); wait_grant(1, 1);
    repeat (2) @(negedge clk);
    #3 reset = 1;
    #1 check("midrst_outputs", 32'({resp_valid, alu_begin, alu_reset_n, alu_inbus, req_ready}), 32'd0);
    alu_q.push_back('{OP_ADD, 8'h20, 8'h00, 8'h02});
    alu_q.push_back('{OP_SUB, 8'h10, 8'h00, 8'h01});
    sb_q.push_back('{2'd1, 8'h22, 8'h00, 1'b0});
    sb_q.push_back('{2'd3, 8'h0F, 8'h00, 1'b0});
    set_req(3, OP_SUB, 8'h10, 8'h01, 8'h00);
    set_req(1, OP_ADD, 8'h20, 8'h02, 8'h00);
    @(negedge clk); #1;
    check("rst_req_ready", 32'({req_ready, alu_reset_n}), 32'd0);
    @(negedge clk);
    reset = 0;
    wait_grant(1, 1);
    wait_grant(3, 1);
    wait_resps(12);

`ifdef ALU_WATCHDOG_EN
    alu_hang = 1;
    alu_q.push_back('{OP_MUL, 8'h00, 8'h05, 8'h05});
    sb_q.push_back('{2'd0, 8'h00, 8'h00, 1'b1});
    set_req(0, OP_MUL, 8'h05, 8'h05, 8'h00); wait_grant(0, 1);
    wait_resps(13);
    alu_hang = 0;
    check("wd_abort_pulses", 32'(abort_cnt), 32'd1);
    check("begin_total", 32'(begin_cnt), 32'd13);
`else
    check("no_abort_pulses", 32'(abort_cnt), 32'd0);
    check("begin_total", 32'(begin_cnt), 32'd12);
`endif
    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("alu_q_empty", 32'(alu_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
